// File: rtl/pcpi_arb_pkg.sv
// Shared types and sizing helpers for the PCPI coprocessor arbiter.
package pcpi_arb_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TMR_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

    // Owner index width; at least one bit so a single-unit build still has a register.
    function automatic int unsigned own_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pcpi_arb_prio_enc.sv
// Lowest-index-first priority encoder: index of the lowest set request bit plus any-hit.
module pcpi_arb_prio_enc
    import pcpi_arb_pkg::*;
#(
    parameter int unsigned N = 2,
    parameter int unsigned W = own_w(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         hit
);

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcpi_cop_arbiter.sv
// Shares one PCPI port between N_COP coprocessors: broadcasts the registered request,
// picks the lowest-index claiming unit as owner, returns its result as one pcpi_ready
// pulse, and drops requests nobody claims within TIMEOUT cycles.
// Optional: define PCPI_ARB_CONFLICT_EN to enable the sticky err_conflict flag.
module pcpi_cop_arbiter
    import pcpi_arb_pkg::*;
#(
    parameter int unsigned N_COP   = 2,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pcpi_valid,
    input  logic [XLEN-1:0]       pcpi_insn,
    input  logic [XLEN-1:0]       pcpi_rs1,
    input  logic [XLEN-1:0]       pcpi_rs2,
    output logic                  pcpi_wr,
    output logic [XLEN-1:0]       pcpi_rd,
    output logic                  pcpi_wait,
    output logic                  pcpi_ready,
    output logic [N_COP-1:0]      cop_valid,
    output logic [XLEN-1:0]       cop_insn,
    output logic [XLEN-1:0]       cop_rs1,
    output logic [XLEN-1:0]       cop_rs2,
    input  logic [N_COP-1:0]      cop_wait,
    input  logic [N_COP-1:0]      cop_ready,
    input  logic [N_COP-1:0]      cop_wr,
    input  logic [XLEN*N_COP-1:0] cop_rd,
    output logic                  err_conflict
);

    localparam int unsigned OWN_W = own_w(N_COP);

    arb_state_e       state, state_d;
    logic [OWN_W-1:0] owner, owner_d;
    logic             has_owner, has_owner_d;
    logic [TMR_W-1:0] timer, timer_d;
    logic [N_COP-1:0] cop_valid_d;
    logic [XLEN-1:0]  cop_insn_d, cop_rs1_d, cop_rs2_d;
    logic             wait_d, ready_d, wr_d;
    logic [XLEN-1:0]  rd_d;

    logic [N_COP-1:0] claim;
    logic [OWN_W-1:0] claim_idx;
    logic             claim_hit;
    logic [XLEN-1:0]  rd_arr [N_COP];

    assign claim = cop_wait | cop_ready;

    pcpi_arb_prio_enc #(
        .N (N_COP),
        .W (OWN_W)
    ) u_prio_enc (
        .req (claim),
        .idx (claim_idx),
        .hit (claim_hit)
    );

    // Unpack the flat per-unit result bus for indexed selection.
    always_comb begin
        for (int i = 0; i < int'(N_COP); i++) begin
            rd_arr[i] = cop_rd[i*XLEN +: XLEN];
        end
    end

    // Next-state and next-output logic for the request FSM.
    always_comb begin
        state_d     = state;
        owner_d     = owner;
        has_owner_d = has_owner;
        timer_d     = timer;
        cop_valid_d = cop_valid;
        cop_insn_d  = cop_insn;
        cop_rs1_d   = cop_rs1;
        cop_rs2_d   = cop_rs2;
        wait_d      = pcpi_wait;
        ready_d     = 1'b0;
        rd_d        = pcpi_rd;
        wr_d        = pcpi_wr;

        case (state)
            IDLE: begin
                if (pcpi_valid) begin
                    cop_insn_d  = pcpi_insn;
                    cop_rs1_d   = pcpi_rs1;
                    cop_rs2_d   = pcpi_rs2;
                    cop_valid_d = '1;
                    timer_d     = TMR_W'(TIMEOUT);
                    owner_d     = '0;
                    has_owner_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (!pcpi_valid) begin
                    // Core withdrew the request: drop it and ignore any late result.
                    cop_valid_d = '0;
                    wait_d      = 1'b0;
                    has_owner_d = 1'b0;
                    state_d     = IDLE;
                end else if (!has_owner) begin
                    if (claim_hit) begin
                        owner_d     = claim_idx;
                        has_owner_d = 1'b1;
                        cop_valid_d = N_COP'(1) << claim_idx;
                        wait_d      = cop_wait[claim_idx];
                        if (cop_ready[claim_idx]) begin
                            rd_d        = rd_arr[claim_idx];
                            wr_d        = cop_wr[claim_idx];
                            cop_valid_d = '0;
                            wait_d      = 1'b0;
                            ready_d     = 1'b1;
                            state_d     = DONE;
                        end
                    end else if (timer <= TMR_W'(1)) begin
                        // Unclaimed for TIMEOUT cycles: withhold pcpi_ready so the core traps.
                        timer_d     = '0;
                        cop_valid_d = '0;
                        state_d     = DRAIN;
                    end else begin
                        timer_d = timer - TMR_W'(1);
                    end
                end else begin
                    wait_d = cop_wait[owner];
                    if (cop_ready[owner]) begin
                        rd_d        = rd_arr[owner];
                        wr_d        = cop_wr[owner];
                        cop_valid_d = '0;
                        wait_d      = 1'b0;
                        ready_d     = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                wait_d  = 1'b0;
                rd_d    = '0;
                wr_d    = 1'b0;
                state_d = DRAIN;
            end
            DRAIN: begin
                // Hold off until the core releases the request so it is not re-dispatched.
                if (!pcpi_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            has_owner  <= 1'b0;
            timer      <= '0;
            cop_valid  <= '0;
            cop_insn   <= '0;
            cop_rs1    <= '0;
            cop_rs2    <= '0;
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b0;
            pcpi_rd    <= '0;
            pcpi_wr    <= 1'b0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            has_owner  <= has_owner_d;
            timer      <= timer_d;
            cop_valid  <= cop_valid_d;
            cop_insn   <= cop_insn_d;
            cop_rs1    <= cop_rs1_d;
            cop_rs2    <= cop_rs2_d;
            pcpi_wait  <= wait_d;
            pcpi_ready <= ready_d;
            pcpi_rd    <= rd_d;
            pcpi_wr    <= wr_d;
        end
    end

`ifdef PCPI_ARB_CONFLICT_EN
    logic             err_q, err_d;
    logic [N_COP-1:0] owner_mask;
    logic             multi_claim, stray_ready;

    assign owner_mask  = N_COP'(1) << owner;
    assign multi_claim = (state == WAIT) && pcpi_valid && !has_owner &&
                         ((claim & (claim - N_COP'(1))) != '0);
    assign stray_ready = (state == WAIT) && has_owner && ((cop_ready & ~owner_mask) != '0);

    // Sticky flag: set on a multi-unit claim or a ready from a non-owner.
    always_comb begin
        err_d = err_q | multi_claim | stray_ready;
    end

    // Conflict flag register, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_conflict = err_q;
`else
    assign err_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_pcpi_cop_arbiter.sv
// Self-checking bench for pcpi_cop_arbiter (N_COP=2, TIMEOUT=8) with a result scoreboard.
module tb_pcpi_cop_arbiter;

    localparam int unsigned N_COP   = 2;
    localparam int unsigned TIMEOUT = 8;
    localparam logic [31:0] INSN_MUL = 32'h02B5_0533;
    localparam logic [31:0] INSN_DIV = 32'h02B5_4533;
`ifdef PCPI_ARB_CONFLICT_EN
    localparam logic CONF_EN = 1'b1;
`else
    localparam logic CONF_EN = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              pcpi_valid;
    logic [31:0]       pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic              pcpi_wr;
    logic [31:0]       pcpi_rd;
    logic              pcpi_wait, pcpi_ready;
    logic [N_COP-1:0]  cop_valid;
    logic [31:0]       cop_insn, cop_rs1, cop_rs2;
    logic [N_COP-1:0]  cop_wait, cop_ready, cop_wr;
    logic [32*N_COP-1:0] cop_rd;
    logic              err_conflict;

    int checks = 0;
    int failures = 0;
    int ready_cnt = 0;
    logic [32:0] sb[$];

    pcpi_cop_arbiter #(
        .N_COP   (N_COP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pcpi_valid   (pcpi_valid),
        .pcpi_insn    (pcpi_insn),
        .pcpi_rs1     (pcpi_rs1),
        .pcpi_rs2     (pcpi_rs2),
        .pcpi_wr      (pcpi_wr),
        .pcpi_rd      (pcpi_rd),
        .pcpi_wait    (pcpi_wait),
        .pcpi_ready   (pcpi_ready),
        .cop_valid    (cop_valid),
        .cop_insn     (cop_insn),
        .cop_rs1      (cop_rs1),
        .cop_rs2      (cop_rs2),
        .cop_wait     (cop_wait),
        .cop_ready    (cop_ready),
        .cop_wr       (cop_wr),
        .cop_rd       (cop_rd),
        .err_conflict (err_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pcpi_ready === 1'b1) ready_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cop();
        cop_wait  = '0;
        cop_ready = '0;
        cop_wr    = '0;
        cop_rd    = '0;
    endtask

    task automatic sb_pop(output logic [32:0] e, output bit empty);
        empty = (sb.size() == 0);
        e = '0;
        if (!empty) e = sb.pop_front();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pcpi_valid = 1'b0;
        pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
        clear_cop();
        tick(); tick();
        checks++;
        if ({pcpi_ready, pcpi_wait, pcpi_wr, pcpi_rd, cop_valid, cop_insn, cop_rs1, cop_rs2, err_conflict} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b wait=%b wr=%b rd=%h cop_valid=%b insn=%h err=%b, all must be 0",
                     pcpi_ready, pcpi_wait, pcpi_wr, pcpi_rd, cop_valid, cop_insn, err_conflict);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mul_wait();
        int r0;
        logic [32:0] e;
        bit empty;
        r0 = ready_cnt;
        pcpi_valid = 1'b1; pcpi_insn = INSN_MUL; pcpi_rs1 = 32'd6; pcpi_rs2 = 32'd7;
        tick();
        checks++;
        if (cop_valid !== 2'b11) begin
            failures++; $display("FAIL mul_dispatch_valid: got %b expected 11", cop_valid);
        end
        checks++;
        if ({cop_insn, cop_rs1, cop_rs2} !== {INSN_MUL, 32'd6, 32'd7}) begin
            failures++; $display("FAIL mul_operands: got %h/%0d/%0d expected %h/6/7", cop_insn, cop_rs1, cop_rs2, INSN_MUL);
        end
        cop_wait = 2'b01;
        sb.push_back({1'b1, 32'd42});
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pcpi_wait !== 1'b1) begin
                failures++; $display("FAIL mul_busy_wait%0d: got %b expected 1", i, pcpi_wait);
            end
        end
        checks++;
        if (cop_valid !== 2'b01) begin
            failures++; $display("FAIL mul_claim_gate: got %b expected 01", cop_valid);
        end
        cop_wait = 2'b00; cop_ready = 2'b01; cop_wr = 2'b01; cop_rd = {32'd0, 32'd42};
        tick();
        checks++;
        if (pcpi_ready !== 1'b1 || pcpi_wait !== 1'b0) begin
            failures++; $display("FAIL mul_ready: ready=%b wait=%b expected 1/0", pcpi_ready, pcpi_wait);
        end
        sb_pop(e, empty);
        checks++;
        if (empty || {pcpi_wr, pcpi_rd} !== e) begin
            failures++; $display("FAIL mul_result: got wr=%b rd=%0d expected wr=%b rd=%0d empty=%0d", pcpi_wr, pcpi_rd, e[32], e[31:0], empty);
        end
        clear_cop();
        tick();
        checks++;
        if ({pcpi_ready, pcpi_wr, pcpi_rd, cop_valid} !== '0) begin
            failures++; $display("FAIL mul_drain_clear: ready=%b wr=%b rd=%0d cop_valid=%b expected all 0", pcpi_ready, pcpi_wr, pcpi_rd, cop_valid);
        end
        pcpi_valid = 1'b0;
        tick();
        checks++;
        if (ready_cnt - r0 !== 1) begin
            failures++; $display("FAIL mul_pulse_count: got %0d expected 1", ready_cnt - r0);
        end
    endtask

    task automatic test_unit1_claim();
        logic [32:0] e;
        bit empty;
        pcpi_valid = 1'b1; pcpi_insn = INSN_DIV; pcpi_rs1 = 32'd100; pcpi_rs2 = 32'd7;
        tick();
        cop_ready = 2'b10; cop_wr = 2'b10; cop_rd = {32'd14, 32'd99};
        sb.push_back({1'b1, 32'd14});
        tick();
        checks++;
        if (pcpi_ready !== 1'b1) begin
            failures++; $display("FAIL div_ready: got %b expected 1", pcpi_ready);
        end
        sb_pop(e, empty);
        checks++;
        if (empty || {pcpi_wr, pcpi_rd} !== e) begin
            failures++; $display("FAIL div_result: got wr=%b rd=%0d expected wr=%b rd=%0d", pcpi_wr, pcpi_rd, e[32], e[31:0]);
        end
        checks++;
        if (cop_valid !== 2'b00) begin
            failures++; $display("FAIL div_valid_cleared: got %b expected 00", cop_valid);
        end
        clear_cop();
        tick();
        pcpi_valid = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int r0;
        int n;
        bit stuck;
        r0 = ready_cnt;
        pcpi_valid = 1'b1; pcpi_insn = 32'h0000_000B; pcpi_rs1 = 32'd1; pcpi_rs2 = 32'd2;
        tick();
        n = 0;
        while (cop_valid !== 2'b00 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n !== int'(TIMEOUT)) begin
            failures++; $display("FAIL timeout_cycles: got %0d cycles of cop_valid expected %0d", n, TIMEOUT);
        end
        stuck = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cop_valid !== 2'b00) stuck = 1'b1;
        end
        checks++;
        if (stuck) begin
            failures++; $display("FAIL timeout_drain_hold: cop_valid rose while request held, got %b expected 00", cop_valid);
        end
        checks++;
        if (ready_cnt !== r0) begin
            failures++; $display("FAIL timeout_no_ready: got %0d pulses expected 0", ready_cnt - r0);
        end
        pcpi_valid = 1'b0;
        tick();
    endtask

    task automatic test_conflict();
        logic [32:0] e;
        bit empty;
        checks++;
        if (err_conflict !== 1'b0) begin
            failures++; $display("FAIL conflict_pre: got %b expected 0", err_conflict);
        end
        pcpi_valid = 1'b1; pcpi_insn = INSN_MUL; pcpi_rs1 = 32'd1; pcpi_rs2 = 32'd5;
        tick();
        cop_ready = 2'b11; cop_wr = 2'b01; cop_rd = {32'd77, 32'd5};
        sb.push_back({1'b1, 32'd5});
        tick();
        sb_pop(e, empty);
        checks++;
        if (pcpi_ready !== 1'b1 || empty || {pcpi_wr, pcpi_rd} !== e) begin
            failures++; $display("FAIL conflict_owner0: ready=%b wr=%b rd=%0d expected 1/%b/%0d", pcpi_ready, pcpi_wr, pcpi_rd, e[32], e[31:0]);
        end
        clear_cop();
        tick();
        checks++;
        if (err_conflict !== CONF_EN) begin
            failures++; $display("FAIL conflict_flag: got %b expected %b", err_conflict, CONF_EN);
        end
        pcpi_valid = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        int r0;
        logic [32:0] e;
        bit empty;
        r0 = ready_cnt;
        pcpi_valid = 1'b1; pcpi_insn = INSN_MUL; pcpi_rs1 = 32'd11; pcpi_rs2 = 32'd3;
        tick();
        tick();
        pcpi_valid = 1'b0;
        cop_ready = 2'b01; cop_wr = 2'b01; cop_rd = {32'd0, 32'd123};
        tick();
        checks++;
        if (cop_valid !== 2'b00 || pcpi_ready !== 1'b0) begin
            failures++; $display("FAIL abort_drop: cop_valid=%b ready=%b expected 00/0", cop_valid, pcpi_ready);
        end
        clear_cop();
        tick();
        checks++;
        if (ready_cnt !== r0) begin
            failures++; $display("FAIL abort_no_ready: got %0d pulses expected 0", ready_cnt - r0);
        end
        pcpi_valid = 1'b1; pcpi_rs1 = 32'd3; pcpi_rs2 = 32'd3;
        tick();
        checks++;
        if (cop_valid !== 2'b11 || cop_rs1 !== 32'd3) begin
            failures++; $display("FAIL abort_redispatch: cop_valid=%b rs1=%0d expected 11/3", cop_valid, cop_rs1);
        end
        cop_ready = 2'b01; cop_wr = 2'b01; cop_rd = {32'd0, 32'd9};
        sb.push_back({1'b1, 32'd9});
        tick();
        sb_pop(e, empty);
        checks++;
        if (pcpi_ready !== 1'b1 || empty || {pcpi_wr, pcpi_rd} !== e) begin
            failures++; $display("FAIL abort_next_result: ready=%b wr=%b rd=%0d expected 1/%b/%0d", pcpi_ready, pcpi_wr, pcpi_rd, e[32], e[31:0]);
        end
        clear_cop();
        tick();
        pcpi_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        logic [32:0] e;
        bit empty;
        pcpi_valid = 1'b1; pcpi_insn = INSN_DIV; pcpi_rs1 = 32'h11; pcpi_rs2 = 32'h22;
        tick();
        cop_wait = 2'b01;
        tick();
        checks++;
        if (pcpi_wait !== 1'b1) begin
            failures++; $display("FAIL rstmid_pre_wait: got %b expected 1", pcpi_wait);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({pcpi_ready, pcpi_wait, pcpi_wr, pcpi_rd, cop_valid, cop_insn, cop_rs1, cop_rs2, err_conflict} !== '0) begin
            failures++; $display("FAIL rstmid_outputs: wait=%b cop_valid=%b insn=%h err=%b expected all 0",
                                 pcpi_wait, cop_valid, cop_insn, err_conflict);
        end
        tick();
        reset = 1'b0;
        clear_cop();
        pcpi_valid = 1'b0;
        tick();
        pcpi_valid = 1'b1; pcpi_insn = INSN_MUL; pcpi_rs1 = 32'd3; pcpi_rs2 = 32'd5;
        tick();
        cop_ready = 2'b01; cop_wr = 2'b01; cop_rd = {32'd0, 32'd15};
        sb.push_back({1'b1, 32'd15});
        tick();
        sb_pop(e, empty);
        checks++;
        if (pcpi_ready !== 1'b1 || empty || {pcpi_wr, pcpi_rd} !== e) begin
            failures++; $display("FAIL rstmid_next_result: ready=%b wr=%b rd=%0d expected 1/%b/%0d", pcpi_ready, pcpi_wr, pcpi_rd, e[32], e[31:0]);
        end
        clear_cop();
        tick();
        pcpi_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_mul_wait();
        test_unit1_claim();
        test_timeout();
        test_conflict();
        test_abort();
        test_reset_mid_wait();
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
